// File: rtl/single_port_data_ram.sv
// Word-organised single-port data RAM: synchronous write, registered write-first read.
// Optional macro ADDR_CHECK_EN restricts accesses to the BASE_ADDR window (default: index wraps).
module single_port_data_ram #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [ADDR_WIDTH-1:0] offset_s;
  logic [IDX_W-1:0]      idx_s;
  logic                  in_window_s;
  logic                  wr_en_s;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Array starts at zero at power-up and is deliberately never reset.
  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH] = '{default: '0};

  // Modular subtraction makes addresses below BASE_ADDR land at the top of the window.
  assign offset_s = addr - BASE_ADDR;
  assign idx_s    = IDX_W'(offset_s >> 2);

`ifdef ADDR_CHECK_EN
  assign in_window_s = ((offset_s >> (IDX_W + 2)) == '0);
`else
  assign in_window_s = 1'b1;
`endif

  assign wr_en_s = we & in_window_s;

  // Next read word: zero outside the window, write-first on a same-edge write.
  always_comb begin
    rdata_d = '0;
    if (!in_window_s) begin
      rdata_d = '0;
    end else if (wr_en_s) begin
      rdata_d = data;
    end else begin
      rdata_d = mem_q[idx_s];
    end
  end

  // Memory array write; blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en_s) begin
      mem_q[idx_s] <= data;
    end
  end

  // Registered read data, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign q = rdata_q;

endmodule

// File: tb/tb_single_port_data_ram.sv
// Directed self-checking bench for single_port_data_ram; expected values are hand-computed.
module tb_single_port_data_ram;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [31:0] addr;
  logic [31:0] data;
  logic [31:0] q;

  int errors;
  int checks;

  single_port_data_ram #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .MEM_DEPTH (64),
    .BASE_ADDR (32'h1001_0000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .addr (addr),
    .data (data),
    .q    (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_powerup();
    we = 1'b0; addr = 32'h1001_0020; data = 32'h0;
    step();
    checks++;
    if (q !== 32'h0) begin
      errors++; $display("FAIL powerup_read q=%h expected=%h", q, 32'h0);
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; addr = 32'h1001_0004; data = 32'h1234_5678;
    step();
    we = 1'b0; data = 32'h0;
    step();
    checks++;
    if (q !== 32'h1234_5678) begin
      errors++; $display("FAIL write_read q=%h expected=%h", q, 32'h1234_5678);
    end
    // low address bits select no byte lane
    addr = 32'h1001_0007;
    step();
    checks++;
    if (q !== 32'h1234_5678) begin
      errors++; $display("FAIL ignore_low_bits q=%h expected=%h", q, 32'h1234_5678);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] words [4];
    words[0] = 32'hFFFF_FFFF; words[1] = 32'h1234_5678;
    words[2] = 32'h9876_1234; words[3] = 32'h10A0_A0A0;
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; addr = 32'h1001_0000 + 32'(4 * i); data = words[i];
      step();
    end
    we = 1'b0; data = 32'h0;
    for (int i = 0; i < 4; i++) begin
      addr = 32'h1001_0000 + 32'(4 * i);
      step();
      checks++;
      if (q !== words[i]) begin
        errors++; $display("FAIL sweep_read%0d q=%h expected=%h", i, q, words[i]);
      end
    end
  endtask

  task automatic test_read_during_write();
    we = 1'b1; addr = 32'h1001_0008; data = 32'hAAAA_AAAA;
    step();
    we = 1'b0;
    step();
    checks++;
    if (q !== 32'hAAAA_AAAA) begin
      errors++; $display("FAIL rdw_before q=%h expected=%h", q, 32'hAAAA_AAAA);
    end
    we = 1'b1; data = 32'hABCD_EF12;
    step();
    checks++;
    if (q !== 32'hABCD_EF12) begin
      errors++; $display("FAIL rdw_same_edge q=%h expected=%h", q, 32'hABCD_EF12);
    end
    we = 1'b0; data = 32'h0;
    step();
    checks++;
    if (q !== 32'hABCD_EF12) begin
      errors++; $display("FAIL rdw_after q=%h expected=%h", q, 32'hABCD_EF12);
    end
  endtask

  task automatic test_reset();
    we = 1'b1; addr = 32'h1001_0000; data = 32'h5A5A_0001;
    step();
    we = 1'b0;
    step();
    checks++;
    if (q !== 32'h5A5A_0001) begin
      errors++; $display("FAIL reset_pre q=%h expected=%h", q, 32'h5A5A_0001);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (q !== 32'h0) begin
      errors++; $display("FAIL reset_async q=%h expected=%h", q, 32'h0);
    end
    // a write attempted under reset must not land
    we = 1'b1; data = 32'hFFFF_0000;
    step();
    checks++;
    if (q !== 32'h0) begin
      errors++; $display("FAIL reset_hold q=%h expected=%h", q, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1; we = 1'b0; data = 32'h0;
    step();
    checks++;
    if (q !== 32'h5A5A_0001) begin
      errors++; $display("FAIL reset_mem_kept q=%h expected=%h", q, 32'h5A5A_0001);
    end
  endtask

`ifndef ADDR_CHECK_EN
  task automatic test_wrap();
    we = 1'b1; addr = 32'h1001_0100; data = 32'h1001_0A14;
    step();
    we = 1'b0; addr = 32'h1001_0000;
    step();
    checks++;
    if (q !== 32'h1001_0A14) begin
      errors++; $display("FAIL wrap_top q=%h expected=%h", q, 32'h1001_0A14);
    end
    we = 1'b1; addr = 32'h1001_00FC; data = 32'h0BAD_F00D;
    step();
    we = 1'b0; addr = 32'h1000_FFFC;
    step();
    checks++;
    if (q !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL wrap_below q=%h expected=%h", q, 32'h0BAD_F00D);
    end
  endtask
`else
  task automatic test_range();
    we = 1'b1; addr = 32'h1001_0000; data = 32'h1111_0000;
    step();
    addr = 32'h1001_0100; data = 32'hDEAD_BEEF;
    step();
    checks++;
    if (q !== 32'h0) begin
      errors++; $display("FAIL range_oow_write q=%h expected=%h", q, 32'h0);
    end
    we = 1'b0;
    step();
    checks++;
    if (q !== 32'h0) begin
      errors++; $display("FAIL range_oow_read q=%h expected=%h", q, 32'h0);
    end
    addr = 32'h1001_0000;
    step();
    checks++;
    if (q !== 32'h1111_0000) begin
      errors++; $display("FAIL range_mem0 q=%h expected=%h", q, 32'h1111_0000);
    end
    we = 1'b1; addr = 32'h1001_00FC; data = 32'h0BAD_F00D;
    step();
    we = 1'b0; addr = 32'h1000_FFFC;
    step();
    checks++;
    if (q !== 32'h0) begin
      errors++; $display("FAIL range_below q=%h expected=%h", q, 32'h0);
    end
    addr = 32'h1001_00FC;
    step();
    checks++;
    if (q !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL range_last q=%h expected=%h", q, 32'h0BAD_F00D);
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0; we = 1'b0; addr = 32'h1001_0000; data = 32'h0;
    #3;
    checks++;
    if (q !== 32'h0) begin
      errors++; $display("FAIL reset_initial q=%h expected=%h", q, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_powerup();
    test_write_read();
    test_sweep();
    test_read_during_write();
    test_reset();
`ifndef ADDR_CHECK_EN
    test_wrap();
`else
    test_range();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
